pll_rst_seq: RTL and testbench

PLL reset and bring-up sequencer running on the free-running board reference clock. It drives the PLL `RESETB` pin and qualifies its `LOCK` output. It then releases a set of downstream reset domains in a fixed order, with a programmable gap between each. It handles lock loss, lock timeout with bounded retries, and software-requested re-sequencing, and replaces the bare lock-driven reset counter in the clock/reset generator.

---
 rtl/pll_rst_seq.sv | 190 +++++++++++++++++++
 tb/tb_pll_rst_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
// PLL reset and bring-up sequencer.
// Pulses the PLL RESETB pin, qualifies a synchronized LOCK, then releases
// downstream reset domains one after another with a fixed gap. Handles lock
// loss, lock timeout with a bounded number of retries, and software re-sequence.
module pll_rst_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILTER    = 8,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int MAX_RETRY      = 3,
    parameter int N_STAGES       = 3,
    parameter int STAGE_DLY      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_lock,
    input  logic                sw_req,
    output logic                pll_reset_n,
    output logic [N_STAGES-1:0] rst_stage,
    output logic                ready,
    output logic                fault,
    output logic [3:0]          retry_cnt
);

    // Counter widths sized to hold the largest value each counter must reach.
    localparam int RW = $clog2(PLL_RST_CYCLES + 1);
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(N_STAGES * STAGE_DLY + 1);

    localparam logic [RW-1:0] RST_LAST   = RW'(PLL_RST_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STAGE_MAX  = SW'(N_STAGES * STAGE_DLY);
    localparam logic [3:0]    RETRY_LAST = 4'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state_reg;
    logic [RW-1:0] rst_cnt_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic [SW-1:0] stage_cnt_reg;
    logic          lock_meta_reg;
    logic          lock_s;

    // One-ahead view of the stage counter; one extra bit so it never wraps.
    logic [SW:0]         stage_cnt_inc;
    logic [N_STAGES-1:0] stage_due;

    assign stage_cnt_inc = {1'b0, stage_cnt_reg} + (SW+1)'(1);

    // Stage k is due once (k+1)*STAGE_DLY cycles have elapsed in RELEASE.
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_due
        assign stage_due[gi] = (stage_cnt_inc >= (SW+1)'((gi + 1) * STAGE_DLY));
    end

    // Two-flop synchronizer for the asynchronous PLL lock pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_reg <= 1'b0;
            lock_s        <= 1'b0;
        end else begin
            lock_meta_reg <= pll_lock;
            lock_s        <= lock_meta_reg;
        end
    end

    // Sequencer FSM with registered outputs; priority rst > sw_req > lock events.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_PLL_RST;
            rst_cnt_reg   <= '0;
            filt_cnt_reg  <= '0;
            tmo_cnt_reg   <= '0;
            stage_cnt_reg <= '0;
            pll_reset_n   <= 1'b0;
            rst_stage     <= '1;
            ready         <= 1'b0;
            fault         <= 1'b0;
            retry_cnt     <= '0;
        end else if (sw_req) begin
            state_reg     <= S_PLL_RST;
            rst_cnt_reg   <= '0;
            filt_cnt_reg  <= '0;
            tmo_cnt_reg   <= '0;
            stage_cnt_reg <= '0;
            pll_reset_n   <= 1'b0;
            rst_stage     <= '1;
            ready         <= 1'b0;
            fault         <= 1'b0;
            retry_cnt     <= '0;
        end else begin
            case (state_reg)
                S_PLL_RST: begin
                    pll_reset_n <= 1'b0;
                    rst_stage   <= '1;
                    ready       <= 1'b0;
                    if (rst_cnt_reg == RST_LAST) begin
                        state_reg    <= S_WAIT_LOCK;
                        rst_cnt_reg  <= '0;
                        filt_cnt_reg <= '0;
                        tmo_cnt_reg  <= '0;
                        pll_reset_n  <= 1'b1;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + RW'(1);
                    end
                end

                S_WAIT_LOCK: begin
                    if (lock_s && filt_cnt_reg == FILT_LAST) begin
                        // Qualified lock wins over a timeout on the same cycle.
                        state_reg     <= S_RELEASE;
                        filt_cnt_reg  <= '0;
                        tmo_cnt_reg   <= '0;
                        stage_cnt_reg <= '0;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        filt_cnt_reg <= '0;
                        tmo_cnt_reg  <= '0;
                        pll_reset_n  <= 1'b0;
                        retry_cnt    <= retry_cnt + 4'd1;
                        if (retry_cnt == RETRY_LAST) begin
                            state_reg <= S_FAIL;
                            fault     <= 1'b1;
                        end else begin
                            state_reg   <= S_PLL_RST;
                            rst_cnt_reg <= '0;
                        end
                    end else begin
                        // A single low sample only restarts the filter; timeout keeps running.
                        tmo_cnt_reg  <= tmo_cnt_reg + TW'(1);
                        filt_cnt_reg <= lock_s ? filt_cnt_reg + FW'(1) : '0;
                    end
                end

                S_RELEASE: begin
                    if (!lock_s) begin
                        state_reg     <= S_PLL_RST;
                        rst_cnt_reg   <= '0;
                        stage_cnt_reg <= '0;
                        pll_reset_n   <= 1'b0;
                        rst_stage     <= '1;
                        ready         <= 1'b0;
                    end else if (!rst_stage[N_STAGES-1]) begin
                        state_reg     <= S_RUN;
                        stage_cnt_reg <= '0;
                        ready         <= 1'b1;
                        retry_cnt     <= '0;
                    end else begin
                        rst_stage <= rst_stage & ~stage_due;
                        if (stage_cnt_reg != STAGE_MAX) begin
                            stage_cnt_reg <= stage_cnt_reg + SW'(1);
                        end
                    end
                end

                S_RUN: begin
                    if (!lock_s) begin
                        state_reg   <= S_PLL_RST;
                        rst_cnt_reg <= '0;
                        pll_reset_n <= 1'b0;
                        rst_stage   <= '1;
                        ready       <= 1'b0;
                    end else begin
                        ready     <= 1'b1;
                        retry_cnt <= '0;
                    end
                end

                S_FAIL: begin
                    pll_reset_n <= 1'b0;
                    rst_stage   <= '1;
                    ready       <= 1'b0;
                    fault       <= 1'b1;
                end

                default: begin
                    state_reg   <= S_PLL_RST;
                    rst_cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq. Instance a runs the default parameters
// (bring-up, lock loss, sw_req, rst, chatter); instance b uses a short lock
// timeout for the retry/fault path. Edge numbers count from the last edge
// at which the relevant rst was sampled high (edge 0).
module tb_pll_rst_seq;

    logic       clk = 1'b0;
    logic       rst_a, lock_a, sw_a;
    logic       rst_b, lock_b, sw_b;
    logic       pll_a, rdy_a, flt_a;
    logic       pll_b, rdy_b, flt_b;
    logic [2:0] stg_a, stg_b;
    logic [3:0] rc_a, rc_b;

    int vectors     = 0;
    int miscompares = 0;
    int t           = 0;

    always #5 clk = ~clk;

    pll_rst_seq dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .pll_lock   (lock_a),
        .sw_req     (sw_a),
        .pll_reset_n(pll_a),
        .rst_stage  (stg_a),
        .ready      (rdy_a),
        .fault      (flt_a),
        .retry_cnt  (rc_a)
    );

    pll_rst_seq #(.LOCK_TIMEOUT(64)) dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .pll_lock   (lock_b),
        .sw_req     (sw_b),
        .pll_reset_n(pll_b),
        .rst_stage  (stg_b),
        .ready      (rdy_b),
        .fault      (flt_b),
        .retry_cnt  (rc_b)
    );

    // Advance to 1 time unit after edge number 'target'.
    task automatic goto(input int target);
        if (t < target) begin
            while (t < target) begin
                @(posedge clk);
                t++;
            end
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; lock_a = 1'b0; sw_a = 1'b0;
        rst_b = 1'b1; lock_b = 1'b0; sw_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        t = 0;

        // ---- reset state ----
        chk("rst_pll_n", pll_a, 0);
        chk("rst_stage", stg_a, 3'b111);
        chk("rst_ready", rdy_a, 0);
        chk("rst_fault", flt_a, 0);
        chk("rst_retry", rc_a, 0);
        rst_a = 1'b0;

        // ---- normal bring-up ----
        goto(15);  chk("up_pll_low", pll_a, 0);
        goto(16);  chk("up_pll_rise", pll_a, 1);
                   chk("up_stage_held", stg_a, 3'b111);
        goto(100); lock_a = 1'b1;
        // raw lock at edge 101 -> RELEASE entered at edge 110
        goto(125); chk("up_s0_before", stg_a, 3'b111);
        goto(126); chk("up_s0_fall", stg_a, 3'b110);
        goto(141); chk("up_s1_before", stg_a, 3'b110);
        goto(142); chk("up_s1_fall", stg_a, 3'b100);
        goto(157); chk("up_s2_before", stg_a, 3'b100);
        goto(158); chk("up_s2_fall", stg_a, 3'b000);
                   chk("up_ready_before", rdy_a, 0);
        goto(159); chk("up_ready", rdy_a, 1);
                   chk("up_retry", rc_a, 0);
                   chk("up_fault", flt_a, 0);

        // ---- one-cycle lock loss in RUN ----
        goto(170); lock_a = 1'b0;
        goto(171); lock_a = 1'b1;
        goto(172); chk("ll_ready_hold", rdy_a, 1);
                   chk("ll_stage_hold", stg_a, 3'b000);
        goto(173); chk("ll_stage", stg_a, 3'b111);
                   chk("ll_ready", rdy_a, 0);
                   chk("ll_pll", pll_a, 0);
                   chk("ll_retry", rc_a, 0);
        goto(188); chk("ll_pll_low", pll_a, 0);
        goto(189); chk("ll_pll_rise", pll_a, 1);
        goto(212); chk("ll_s0_before", stg_a, 3'b111);
        goto(213); chk("ll_s0_fall", stg_a, 3'b110);
        goto(245); chk("ll_s2_fall", stg_a, 3'b000);
        goto(246); chk("ll_ready_up", rdy_a, 1);

        // ---- sw_req in RUN ----
        sw_a = 1'b1;
        goto(247); sw_a = 1'b0;
                   chk("swrun_stage", stg_a, 3'b111);
                   chk("swrun_ready", rdy_a, 0);
                   chk("swrun_pll", pll_a, 0);
        goto(262); chk("swrun_pll_low", pll_a, 0);
        goto(263); chk("swrun_pll_rise", pll_a, 1);

        // ---- sw_req in RELEASE after stage 0 released (RELEASE at 271) ----
        goto(287); chk("swrel_s0", stg_a, 3'b110);
        goto(290); sw_a = 1'b1;
        goto(291); sw_a = 1'b0;
                   chk("swrel_stage", stg_a, 3'b111);
                   chk("swrel_pll", pll_a, 0);
        goto(306); chk("swrel_pll_low", pll_a, 0);
        goto(307); chk("swrel_pll_rise", pll_a, 1);
        goto(364); chk("swrel_ready", rdy_a, 1);
                   chk("swrel_stage_done", stg_a, 3'b000);

        // ---- rst in RUN ----
        goto(366); rst_a = 1'b1;
        goto(367); chk("rstrun_pll", pll_a, 0);
                   chk("rstrun_stage", stg_a, 3'b111);
                   chk("rstrun_ready", rdy_a, 0);
                   chk("rstrun_fault", flt_a, 0);
                   chk("rstrun_retry", rc_a, 0);

        // ---- lock chatter (period 6) ----
        goto(368); t = 0; rst_a = 1'b0;
        for (int i = 0; i < 200; i++) begin
            lock_a = ((i / 3) % 2 == 0);
            goto(i + 1);
            chk("chat_hold", stg_a, 3'b111);
        end
        lock_a = 1'b1;
        // steady high from edge 199 -> RELEASE entered at edge 208
        goto(223); chk("chat_s0_before", stg_a, 3'b111);
        goto(224); chk("chat_s0_fall", stg_a, 3'b110);

        // ---- timeout and retry (instance b, LOCK_TIMEOUT=64) ----
        goto(230); t = 0; rst_b = 1'b0;
        chk("to_rst_pll", pll_b, 0);
        chk("to_rst_retry", rc_b, 0);
        goto(15);  chk("to_p1_low", pll_b, 0);
        goto(16);  chk("to_p1_rise", pll_b, 1);
        goto(79);  chk("to_r0", rc_b, 0);
                   chk("to_w1_pll", pll_b, 1);
        goto(80);  chk("to_r1", rc_b, 1);
                   chk("to_p2_fall", pll_b, 0);
        goto(95);  chk("to_p2_low", pll_b, 0);
        goto(96);  chk("to_p2_rise", pll_b, 1);
        goto(159); chk("to_r1_hold", rc_b, 1);
        goto(160); chk("to_r2", rc_b, 2);
        goto(175); chk("to_p3_low", pll_b, 0);
        goto(176); chk("to_p3_rise", pll_b, 1);
        goto(239); chk("to_nofault", flt_b, 0);
        goto(240); chk("to_r3", rc_b, 3);
                   chk("to_fault", flt_b, 1);
                   chk("to_fail_pll", pll_b, 0);
        goto(300); chk("fail_pll_stuck", pll_b, 0);
                   chk("fail_fault", flt_b, 1);
                   chk("fail_stage", stg_b, 3'b111);
                   chk("fail_retry", rc_b, 3);
                   chk("fail_ready", rdy_b, 0);
        sw_b = 1'b1;
        goto(301); sw_b = 1'b0;
                   chk("swfail_fault", flt_b, 0);
                   chk("swfail_retry", rc_b, 0);
                   chk("swfail_pll", pll_b, 0);
        goto(316); chk("swfail_pll_low", pll_b, 0);
        goto(317); chk("swfail_pll_rise", pll_b, 1);

        // ---- lock loss in RELEASE keeps retry_cnt ----
        goto(380); chk("ret_r0", rc_b, 0);
        goto(381); chk("ret_r1", rc_b, 1);
        lock_b = 1'b1;
        // RELEASE entered at edge 405
        goto(410); chk("rel_retry", rc_b, 1);
                   chk("rel_stage", stg_b, 3'b111);
                   chk("rel_pll", pll_b, 1);
        lock_b = 1'b0;
        goto(411); lock_b = 1'b1;
        goto(412); chk("rel_ll_pll_hold", pll_b, 1);
        goto(413); chk("rel_ll_pll", pll_b, 0);
                   chk("rel_ll_retry", rc_b, 1);
                   chk("rel_ll_stage", stg_b, 3'b111);
        goto(429); chk("rel_ll_pll_rise", pll_b, 1);

        // ---- sw_req coinciding with lock loss (RELEASE at 437) ----
        goto(440); lock_b = 1'b0;
        goto(441); lock_b = 1'b1;
        goto(442); sw_b = 1'b1;
        goto(443); sw_b = 1'b0;
                   chk("swll_retry", rc_b, 0);
                   chk("swll_fault", flt_b, 0);
                   chk("swll_pll", pll_b, 0);
                   chk("swll_stage", stg_b, 3'b111);
                   chk("swll_ready", rdy_b, 0);
        goto(458); chk("swll_pll_low", pll_b, 0);
        goto(459); chk("swll_pll_rise", pll_b, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
